// File: rtl/fase_sequencer.sv
// Timed green/amber phase sequencer feeding the light decoder; 4 approaches,
// demand-based skipping, safe entry to and exit from flashing amber.
module fase_sequencer #(
   parameter int CLK_HZ  = 27_000_000,
   parameter int GREEN_S = 20,
   parameter int AMBAR_S = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       flash_req,
   input  logic [3:0] demanda,
   input  logic       cfg_we,
   input  logic [7:0] cfg_verde,
   input  logic [3:0] cfg_ambar,
   output logic [3:0] ciclo,
   output logic       fase_ini,
   output logic [7:0] seg_rest
);
   typedef enum logic [1:0] {FLASH, VERDE, AMBAR} state_t;

   localparam int            PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

   state_t        state, state_n;
   logic [1:0]    idx, idx_n, nxt;
   logic [PW-1:0] pre, pre_n;
   logic [7:0]    sec_cnt, sec_n, len_reg, len_n;
   logic [7:0]    verde_reg;
   logic [3:0]    ambar_reg;
   logic          tick, last, entry;
   logic [3:0]    ciclo_n;
   logic [7:0]    seg_n;

   assign tick = (pre == PRE_MAX);
   assign last = tick && (sec_cnt == len_reg - 8'd1);

   // Rotating priority search starting after the current approach; the
   // current approach is checked last. No demand at all gives plain rotation.
   always_comb begin
      logic [1:0] cand;
      logic       found;
      nxt   = idx + 2'd1;
      found = 1'b0;
      cand  = idx;
      for (int k = 1; k <= 4; k++) begin
         cand = idx + 2'(k);
         if (!found && demanda[cand]) begin
            nxt   = cand;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      case (state)
         FLASH: if (run && !flash_req) begin
            state_n = VERDE;
            idx_n   = 2'd0;
         end
         VERDE: if (flash_req || last) state_n = AMBAR;
         AMBAR: if (last) begin
            if (flash_req || !run) state_n = FLASH;
            else begin
               state_n = VERDE;
               idx_n   = nxt;
            end
         end
         default: state_n = FLASH;
      endcase
      entry = (state_n != state);

      // Length comes from the config registers as they stood before this edge,
      // so a write coinciding with entry only affects later phases.
      if (state_n == FLASH || entry) begin
         pre_n = '0;
         sec_n = 8'd0;
      end else begin
         pre_n = tick ? '0 : pre + PW'(1);
         sec_n = tick ? sec_cnt + 8'd1 : sec_cnt;
      end
      if (entry) len_n = (state_n == VERDE) ? verde_reg : {4'd0, ambar_reg};
      else       len_n = len_reg;
   end

   always_comb begin
      ciclo_n = 4'd0;
      seg_n   = 8'd0;
      if (state_n != FLASH) begin
         ciclo_n = {1'b0, idx_n, 1'b0} + ((state_n == VERDE) ? 4'd1 : 4'd2);
         seg_n   = len_n - sec_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FLASH;
         idx       <= 2'd0;
         pre       <= '0;
         sec_cnt   <= 8'd0;
         len_reg   <= 8'd0;
         verde_reg <= 8'(GREEN_S);
         ambar_reg <= 4'(AMBAR_S);
         ciclo     <= 4'd0;
         fase_ini  <= 1'b0;
         seg_rest  <= 8'd0;
      end else begin
         state    <= state_n;
         idx      <= idx_n;
         pre      <= pre_n;
         sec_cnt  <= sec_n;
         len_reg  <= len_n;
         ciclo    <= ciclo_n;
         fase_ini <= entry;
         seg_rest <= seg_n;
         if (cfg_we && cfg_verde != 8'd0) verde_reg <= cfg_verde;
         if (cfg_we && cfg_ambar != 4'd0) ambar_reg <= cfg_ambar;
      end
   end
endmodule
